// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_fifo
// Purpose  : Serial receive front end for the CPU ser_rx path.
//            - Synchronises the asynchronous rx pin through two flops.
//            - Deserialises 8N1 frames at a fixed baud divisor.
//            - Buffers received bytes in a small circular FIFO.
//            - Provides a show-ahead read port and sticky error flags.
// Build    : Define UART_RX_PARITY_EN to receive 8E1 frames.
//            A PARITY state then follows DATA. The default build
//            receives 8N1 frames only.
// Ports    : clk        system clock; all logic runs on the rising edge
//            resetn     asynchronous, active-low reset
//            rx         raw serial input; idles high; asynchronous to clk
//            rd_en      pops the head byte this cycle
//            rd_data    head byte (show-ahead); 8'h00 when empty
//            rd_valid   FIFO not empty
//            count      number of bytes held, 0..2**FIFO_AW
//            overrun    sticky; a byte was dropped because the FIFO was full
//            frame_err  sticky; a bad stop bit or parity bit was sampled
//            clr_err    clears overrun and frame_err
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_AW      = 3
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               rx,
  input  logic               rd_en,
  output logic [7:0]         rd_data,
  output logic               rd_valid,
  output logic [FIFO_AW:0]   count,
  output logic               overrun,
  output logic               frame_err,
  input  logic               clr_err
);

  localparam int                c_CW    = $clog2(CLKS_PER_BIT);
  localparam logic [c_CW-1:0]   c_FULL  = c_CW'(CLKS_PER_BIT - 1);
  localparam logic [c_CW-1:0]   c_HALF  = c_CW'(CLKS_PER_BIT / 2 - 1);
  localparam int                c_DEPTH = 2 ** FIFO_AW;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_STOP   = 3'd3,
    S_BREAK  = 3'd4
`ifdef UART_RX_PARITY_EN
    ,S_PARITY = 3'd5
`endif
  } state_t;

  // --------------------------------------------------------------------------
  // Input synchroniser and falling-edge detect.
  // All three flops reset high, which is the idle level of the line.
  // --------------------------------------------------------------------------
  logic r_rx_meta;
  logic r_rx_sync;
  logic r_rx_prev;
  logic w_fall;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_sync <= r_rx_meta;
      r_rx_prev <= r_rx_sync;
    end
  end

  assign w_fall = r_rx_prev & ~r_rx_sync;

  // --------------------------------------------------------------------------
  // Receive FSM.
  // The baud and bit counters are cleared on every state transition.
  // START samples at the mid-point of the start bit. Every later sample then
  // falls a whole bit period further on, which is the centre of each bit.
  // --------------------------------------------------------------------------
  state_t          r_state;
  logic [c_CW-1:0] r_baud;
  logic [2:0]      r_bit;
  logic [7:0]      r_shift;
  logic            r_push;
  logic            r_frame_err;
`ifdef UART_RX_PARITY_EN
  logic            r_par_bad;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= S_IDLE;
      r_baud      <= '0;
      r_bit       <= '0;
      r_shift     <= '0;
      r_push      <= 1'b0;
      r_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par_bad   <= 1'b0;
`endif
    end else begin
      r_push <= 1'b0;
      // A set in the same cycle is assigned later below, so the set wins.
      if (clr_err) begin
        r_frame_err <= 1'b0;
      end
      case (r_state)
        S_IDLE: begin
          r_baud <= '0;
          r_bit  <= '0;
          if (w_fall) begin
            r_state <= S_START;
          end
        end
        S_START: begin
          if (r_baud == c_HALF) begin
            r_baud  <= '0;
            r_bit   <= '0;
            // A line that is high again at mid-bit was a glitch. Drop it silently.
            r_state <= r_rx_sync ? S_IDLE : S_DATA;
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        S_DATA: begin
          if (r_baud == c_FULL) begin
            r_baud  <= '0;
            r_shift <= {r_rx_sync, r_shift[7:1]};
            if (r_bit == 3'd7) begin
              r_bit   <= '0;
`ifdef UART_RX_PARITY_EN
              r_state <= S_PARITY;
`else
              r_state <= S_STOP;
`endif
            end else begin
              r_bit <= r_bit + 1'b1;
            end
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (r_baud == c_FULL) begin
            r_baud  <= '0;
            r_bit   <= '0;
            r_state <= S_STOP;
            if (r_rx_sync != (^r_shift)) begin
              r_par_bad   <= 1'b1;
              r_frame_err <= 1'b1;
            end else begin
              r_par_bad <= 1'b0;
            end
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
`endif
        S_STOP: begin
          if (r_baud == c_FULL) begin
            r_baud <= '0;
            r_bit  <= '0;
            if (r_rx_sync) begin
              r_state <= S_IDLE;
`ifdef UART_RX_PARITY_EN
              r_push  <= ~r_par_bad;
`else
              r_push  <= 1'b1;
`endif
            end else begin
              r_frame_err <= 1'b1;
              r_state     <= S_BREAK;
            end
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        S_BREAK: begin
          r_baud <= '0;
          r_bit  <= '0;
          if (r_rx_sync) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_baud  <= '0;
          r_bit   <= '0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // FIFO.
  // The pointers carry one extra wrap bit, which tells full apart from empty.
  // When the FIFO is full, the write slot and the read slot are the same slot.
  // A simultaneous push and pop is still correct in that case: the head is
  // read combinationally before the clock edge overwrites it.
  // --------------------------------------------------------------------------
  logic [7:0]       r_mem [0:c_DEPTH-1];
  logic [FIFO_AW:0] r_wr;
  logic [FIFO_AW:0] r_rd;
  logic             r_overrun;
  logic             w_empty;
  logic             w_full;
  logic             w_pop;
  logic             w_wr;

  assign w_empty = (r_wr == r_rd);
  assign w_full  = (r_wr[FIFO_AW] != r_rd[FIFO_AW]) &&
                   (r_wr[FIFO_AW-1:0] == r_rd[FIFO_AW-1:0]);
  assign w_pop   = rd_en & ~w_empty;
  assign w_wr    = r_push & (~w_full | w_pop);

  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr[FIFO_AW-1:0]] <= r_shift;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr      <= '0;
      r_rd      <= '0;
      r_overrun <= 1'b0;
    end else begin
      if (w_wr) begin
        r_wr <= r_wr + 1'b1;
      end
      if (w_pop) begin
        r_rd <= r_rd + 1'b1;
      end
      if (clr_err) begin
        r_overrun <= 1'b0;
      end
      if (r_push && w_full && !w_pop) begin
        r_overrun <= 1'b1;
      end
    end
  end

  assign rd_data   = w_empty ? 8'h00 : r_mem[r_rd[FIFO_AW-1:0]];
  assign rd_valid  = ~w_empty;
  assign count     = r_wr - r_rd;
  assign overrun   = r_overrun;
  assign frame_err = r_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_fifo
// Purpose  : Directed, self-checking bench for uart_rx_fifo.
//            The design is built with CLKS_PER_BIT=4 and FIFO_AW=2.
//            Stimulus is driven on falling clock edges.
//            Outputs are checked on falling edges, away from the active edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_fifo;

  localparam int CPB = 4;
  localparam int AW  = 2;

  logic          clk     = 1'b0;
  logic          resetn  = 1'b0;
  logic          rx      = 1'b1;
  logic          rd_en   = 1'b0;
  logic          clr_err = 1'b0;
  logic [7:0]    rd_data;
  logic          rd_valid;
  logic [AW:0]   count;
  logic          overrun;
  logic          frame_err;

  int n_vec = 0;
  int n_err = 0;

  uart_rx_fifo #(
    .CLKS_PER_BIT (CPB),
    .FIFO_AW      (AW)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .rx        (rx),
    .rd_en     (rd_en),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .count     (count),
    .overrun   (overrun),
    .frame_err (frame_err),
    .clr_err   (clr_err)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drives one frame: start bit, eight data bits LSB first, an optional
  // parity bit, then the stop bit. Each bit is held for CPB clocks.
  // The task returns on a falling edge. At that point the stop bit is sampled
  // on the next rising edge, and the byte is pushed on the rising edge after.
  task automatic send_raw(input logic [7:0] d, input logic par, input logic stop);
    rx = 1'b0;
    idle(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      idle(CPB);
    end
`ifdef UART_RX_PARITY_EN
    rx = par;
    idle(CPB);
`else
    rx = par | 1'b1;
`endif
    rx = stop;
    idle(CPB);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    send_raw(d, ^d, stop);
  endtask

  task automatic send_byte(input logic [7:0] d);
    send_frame(d, 1'b1);
    idle(3);
  endtask

  task automatic pop_expect(input string tag, input logic [7:0] exp);
    check_val({tag, "_valid"}, {31'd0, rd_valid}, 32'd1);
    check_val({tag, "_data"}, {24'd0, rd_data}, {24'd0, exp});
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  initial begin
    // Reset state
    idle(2);
    check_val("rst_valid", {31'd0, rd_valid}, 32'd0);
    check_val("rst_count", {29'd0, count}, 32'd0);
    check_val("rst_data", {24'd0, rd_data}, 32'd0);
    check_val("rst_ovr", {31'd0, overrun}, 32'd0);
    check_val("rst_ferr", {31'd0, frame_err}, 32'd0);
    resetn = 1'b1;
    idle(4);

    // 8'hA5: the push lands exactly one clock after the stop-bit sample
    send_frame(8'hA5, 1'b1);
    @(negedge clk);
    check_val("a5_cnt_pre", {29'd0, count}, 32'd0);
    @(negedge clk);
    check_val("a5_cnt", {29'd0, count}, 32'd1);
    check_val("a5_valid", {31'd0, rd_valid}, 32'd1);
    check_val("a5_data", {24'd0, rd_data}, 32'hA5);
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    check_val("a5_pop_cnt", {29'd0, count}, 32'd0);
    check_val("a5_pop_data", {24'd0, rd_data}, 32'd0);
    check_val("a5_pop_valid", {31'd0, rd_valid}, 32'd0);

    // A one-cycle low glitch is rejected; the next frame is still received
    idle(2);
    rx = 1'b0;
    @(negedge clk);
    rx = 1'b1;
    idle(20);
    check_val("gl_cnt", {29'd0, count}, 32'd0);
    check_val("gl_ferr", {31'd0, frame_err}, 32'd0);
    send_byte(8'h5A);
    check_val("gl_next_cnt", {29'd0, count}, 32'd1);
    pop_expect("gl_next", 8'h5A);

    // Bad stop bit followed by a break; the next byte arrives once rx is high
    idle(2);
    send_frame(8'h3C, 1'b0);
    idle(20);
    check_val("brk_ferr", {31'd0, frame_err}, 32'd1);
    check_val("brk_cnt", {29'd0, count}, 32'd0);
    rx = 1'b1;
    idle(4);
    send_byte(8'h01);
    check_val("brk_next_cnt", {29'd0, count}, 32'd1);
    pop_expect("brk_next", 8'h01);
    check_val("ferr_sticky", {31'd0, frame_err}, 32'd1);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    check_val("ferr_clr", {31'd0, frame_err}, 32'd0);

    // Overrun: five bytes arrive with no reads
    for (int i = 0; i < 5; i++) begin
      send_byte(8'h10 + 8'(i));
    end
    check_val("ovr_cnt", {29'd0, count}, 32'd4);
    check_val("ovr_flag", {31'd0, overrun}, 32'd1);
    pop_expect("ovr_p0", 8'h10);
    pop_expect("ovr_p1", 8'h11);
    pop_expect("ovr_p2", 8'h12);
    pop_expect("ovr_p3", 8'h13);
    check_val("ovr_empty", {31'd0, rd_valid}, 32'd0);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    check_val("ovr_clr", {31'd0, overrun}, 32'd0);

    // Full FIFO, with a pop in the same cycle as the push
    for (int i = 0; i < 4; i++) begin
      send_byte(8'h20 + 8'(i));
    end
    check_val("full_cnt", {29'd0, count}, 32'd4);
    send_frame(8'h24, 1'b1);
    @(negedge clk);
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    check_val("fpp_cnt", {29'd0, count}, 32'd4);
    check_val("fpp_ovr", {31'd0, overrun}, 32'd0);
    pop_expect("fpp_p0", 8'h21);
    pop_expect("fpp_p1", 8'h22);
    pop_expect("fpp_p2", 8'h23);
    pop_expect("fpp_p3", 8'h24);

    // Reset in the middle of the DATA phase of 8'hFF
    idle(2);
    send_byte(8'h77);
    check_val("pre_rst_cnt", {29'd0, count}, 32'd1);
    rx = 1'b0;
    idle(CPB);
    rx = 1'b1;
    idle(6);
    resetn = 1'b0;
    #1;
    check_val("mrst_cnt", {29'd0, count}, 32'd0);
    check_val("mrst_valid", {31'd0, rd_valid}, 32'd0);
    check_val("mrst_data", {24'd0, rd_data}, 32'd0);
    check_val("mrst_ovr", {31'd0, overrun}, 32'd0);
    check_val("mrst_ferr", {31'd0, frame_err}, 32'd0);
    idle(2);
    resetn = 1'b1;
    idle(40);
    check_val("mrst_no_push", {29'd0, count}, 32'd0);
    send_byte(8'h55);
    check_val("post_rst_cnt", {29'd0, count}, 32'd1);
    pop_expect("post_rst", 8'h55);

`ifdef UART_RX_PARITY_EN
    // 8'h07 has odd weight, so the correct even-parity bit is 1
    idle(2);
    send_raw(8'h07, 1'b0, 1'b1);
    idle(3);
    check_val("par_bad_ferr", {31'd0, frame_err}, 32'd1);
    check_val("par_bad_cnt", {29'd0, count}, 32'd0);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    send_raw(8'h07, 1'b1, 1'b1);
    idle(3);
    check_val("par_ok_cnt", {29'd0, count}, 32'd1);
    check_val("par_ok_ferr", {31'd0, frame_err}, 32'd0);
    pop_expect("par_ok", 8'h07);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
